os_psum_writer: RTL and testbench
=================================

# os_psum_writer

Serial-to-parallel writer for the output-stationary datapath: it accepts one psum_bw-wide word per handshake and assembles a full flattened col×row psum image. Once the image is complete, it presents the image to the mac_array side with a valid/ready handshake. It is the write-side counterpart of the serial psum readout, using the same word ordering, so a serial stream read out of one array can be written back verbatim, e.g. for psum preload or accumulation-resume.

## Interface
- psum_bw, 16, bits per psum word
- col, 8, array columns
- row, 8, array rows
- cnt_bw, 7, word counter width; must satisfy 2^cnt_bw > col*row
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- clear  input  1  synchronous abort; returns block to empty FILL state
- in_valid  input  1  in_data holds a word
- in_data  input  psum_bw  psum word
- in_ready  output  1  block can accept a word this cycle
- array_ready  input  1  consumer takes os_in_array this cycle
- array_valid  output  1  os_in_array holds a complete image
- os_in_array  output  psum_bw*col*row  assembled image, word k at bits [k*psum_bw +: psum_bw]
- word_cnt  output  cnt_bw  words accepted in current image (0..col*row)

## Operation
- Two states: FILL and HOLD. Reset state is FILL.
- FILL:
  - in_ready=1, array_valid=0.
  - On accept (in_valid & in_ready): write in_data to slot word_cnt, then increment word_cnt.
  - Accepting slot col*row-1 moves the block to HOLD with word_cnt=col*row.
- HOLD:
  - in_ready=0, array_valid=1, os_in_array stable.
  - On array_ready=1: return to FILL and set word_cnt=0.
  - Buffer contents are retained and overwritten slot by slot during the next fill.
- Ordering: word 0 goes to the LSBs and word col*row-1 to the MSBs. This matches the serial readout order, in which offset i advances by psum_bw per word.
- Slots not yet written in the current fill hold their previous contents; after reset or clear they hold 0.
- in_data is ignored whenever in_ready=0. It is never written, and word_cnt does not change.
- clear:
  - Has priority over every other event.
  - Next state is FILL, word_cnt=0, whole buffer zeroed.
  - Any word presented in the same cycle is dropped.
- clear in HOLD with array_ready=1 in the same cycle: the consumer has sampled the image at that edge (valid&ready), and the block still zeroes the buffer and enters FILL.
- array_ready is ignored in FILL.
- in_valid in HOLD does not stall or corrupt anything; the upstream simply waits for in_ready.

## Timing
- Reset values (asynchronous, while reset=1): state FILL, in_ready=1, array_valid=0, word_cnt=0, os_in_array=0.
- in_ready and array_valid are decoded from registered state only, with no combinational path from inputs.
- Accept latency: a word accepted at edge t appears in os_in_array and word_cnt after edge t.
- array_valid rises the cycle after the edge that accepts the last word.
- The image is released at the edge where array_valid & array_ready. in_ready=1 in the following cycle.
- Throughput: col*row accept cycles plus at least 1 HOLD cycle per image, i.e. 65 cycles minimum at default parameters.
- In HOLD with array_ready and in_valid both high: the image is transferred, the word is not accepted that cycle, and the same word is accepted in the next cycle if still presented.
- Reset asserted mid-fill or in HOLD: the partial or complete image is discarded, and all outputs take their reset values immediately.

## Test plan
- **Reset:** assert reset mid-cycle with word_cnt=10 -> immediately word_cnt=0, os_in_array=0, in_ready=1, array_valid=0.
- **Full fill:** stream 64 words 0x0000..0x003F with in_valid held high.
  - array_valid=1 the cycle after word 63 is accepted.
  - os_in_array[15:0]=0x0000, [31:16]=0x0001, [1023:1008]=0x003F; word_cnt=64.
- **Bubbles and backpressure:**
  - Toggle in_valid randomly during fill -> image identical to the gap-free case.
  - Hold array_ready=0 for 5 HOLD cycles while in_valid=1 -> in_ready=0 and os_in_array unchanged throughout.
- **Release/refill overlap:** array_ready=1 and in_valid=1 (data 0xBEEF) in the same HOLD cycle.
  - Transfer happens and 0xBEEF is not accepted that cycle.
  - Next cycle 0xBEEF is accepted into slot 0, and word_cnt=1.
- **Clear mid-fill:** after 20 words, pulse clear with in_valid=1 -> word_cnt=0, os_in_array=0, and the concurrent word is dropped.
- **Round trip:** feed the writer's os_in_array into the serial psum reader -> the reader emits the original 64 words in order.

Source files
------------

// File: rtl/os_psum_writer.sv
// Serial-to-parallel psum writer: collects col*row words one per handshake into a
// flattened image, then offers the image to the mac_array with valid/ready.
module os_psum_writer #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int cnt_bw  = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [psum_bw-1:0]           in_data,
    output logic                         in_ready,
    input  logic                         array_ready,
    output logic                         array_valid,
    output logic [psum_bw*col*row-1:0]   os_in_array,
    output logic [cnt_bw-1:0]            word_cnt
);

    localparam int NWORDS = col * row;
    localparam int IMG_BW = psum_bw * NWORDS;
    localparam logic [cnt_bw-1:0] LAST_SLOT = cnt_bw'(NWORDS - 1);
    localparam logic [cnt_bw-1:0] FULL_CNT  = cnt_bw'(NWORDS);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [cnt_bw-1:0]   cnt_q, cnt_d;
    logic [IMG_BW-1:0]   img_q, img_d;

    // Next-state logic: clear dominates, then the FILL/HOLD handshakes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        if (clear) begin
            state_d = FILL;
            cnt_d   = {cnt_bw{1'b0}};
            img_d   = {IMG_BW{1'b0}};
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        img_d[int'(cnt_q)*psum_bw +: psum_bw] = in_data;
                        if (cnt_q == LAST_SLOT) begin
                            state_d = HOLD;
                            cnt_d   = FULL_CNT;
                        end else begin
                            cnt_d   = cnt_q + cnt_bw'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                HOLD: begin
                    // Buffer is kept so unwritten slots of the next fill retain old data.
                    if (array_ready) begin
                        state_d = FILL;
                        cnt_d   = {cnt_bw{1'b0}};
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = {cnt_bw{1'b0}};
                    img_d   = {IMG_BW{1'b0}};
                end
            endcase
        end
    end

    // State, counter and image registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= {cnt_bw{1'b0}};
            img_q   <= {IMG_BW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign array_valid = (state_q == HOLD);
    assign os_in_array = img_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_os_psum_writer.sv
// Bench for os_psum_writer: word-array reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_os_psum_writer;

    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          array_ready;
    logic          array_valid;
    logic [1023:0] os_in_array;
    logic [6:0]    word_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_img [N];
    int          m_cnt;
    logic        m_hold;

    logic [1023:0] snap;
    logic [15:0]   exp_words [N];

    os_psum_writer dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .array_ready(array_ready), .array_valid(array_valid),
        .os_in_array(os_in_array), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Serial readout of an image: word i lives at offset i*16.
    function automatic int first_bad(input logic [1023:0] img, input logic [15:0] w [N]);
        logic [15:0] rd;
        for (int i = 0; i < N; i++) begin
            rd = img[i*16 +: 16];
            if (rd !== w[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] slot(input int k);
        return os_in_array[k*16 +: 16];
    endfunction

    // Reference model: word array, fill count and a "holding full image" flag.
    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            m_hold <= 1'b0;
            m_cnt  <= 0;
            for (int i = 0; i < N; i++) m_img[i] <= 16'h0000;
        end else if (m_hold) begin
            if (array_ready) begin
                m_hold <= 1'b0;
                m_cnt  <= 0;
            end
        end else if (in_valid) begin
            m_img[m_cnt] <= in_data;
            m_cnt        <= m_cnt + 1;
            if (m_cnt == N - 1) m_hold <= 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, ~m_hold});
        chk("array_valid", {31'd0, array_valid}, {31'd0, m_hold});
        chk("word_cnt", {25'd0, word_cnt}, 32'(m_cnt));
        chk("image_first_bad_slot", 32'(first_bad(os_in_array, m_img)), 32'hFFFF_FFFF);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000; array_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_word_cnt", {25'd0, word_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_array_valid", {31'd0, array_valid}, 32'd0);
        chk("rst_image_zero", {31'd0, os_in_array == 1024'd0}, 32'd1);

        // Gap-free fill 0x0000..0x003F
        for (int k = 0; k < N; k++) send(16'(k));
        chk("full_array_valid", {31'd0, array_valid}, 32'd1);
        chk("full_slot0", {16'd0, slot(0)}, 32'h0000);
        chk("full_slot1", {16'd0, slot(1)}, 32'h0001);
        chk("full_slot63", {16'd0, slot(63)}, 32'h003F);
        chk("full_word_cnt", {25'd0, word_cnt}, 32'd64);
        for (int k = 0; k < N; k++) exp_words[k] = 16'(k);
        chk("roundtrip_img1", 32'(first_bad(os_in_array, exp_words)), 32'hFFFF_FFFF);

        // Backpressure in HOLD with upstream still presenting data
        snap = os_in_array;
        in_valid = 1'b1; in_data = 16'h1234; array_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_image_stable", {31'd0, os_in_array === snap}, 32'd1);
        end

        // Release and refill overlap
        in_data = 16'hBEEF; array_ready = 1'b1;
        step();
        array_ready = 1'b0;
        chk("ovl_array_valid", {31'd0, array_valid}, 32'd0);
        chk("ovl_word_cnt_0", {25'd0, word_cnt}, 32'd0);
        chk("ovl_slot0_retained", {16'd0, slot(0)}, 32'h0000);
        step();
        in_valid = 1'b0;
        chk("ovl_word_cnt_1", {25'd0, word_cnt}, 32'd1);
        chk("ovl_slot0_beef", {16'd0, slot(0)}, 32'hBEEF);

        // Fill remainder with random bubbles
        for (int k = 1; k < N; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
            send(16'h0100 + 16'(k));
        end
        exp_words[0] = 16'hBEEF;
        for (int k = 1; k < N; k++) exp_words[k] = 16'h0100 + 16'(k);
        chk("bubble_array_valid", {31'd0, array_valid}, 32'd1);
        chk("bubble_slot63", {16'd0, slot(63)}, 32'h013F);
        chk("roundtrip_img2", 32'(first_bad(os_in_array, exp_words)), 32'hFFFF_FFFF);
        array_ready = 1'b1;
        step();
        array_ready = 1'b0;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Clear mid-fill drops the concurrent word
        for (int k = 0; k < 20; k++) send(16'h0200 + 16'(k));
        chk("pre_clear_cnt", {25'd0, word_cnt}, 32'd20);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_word_cnt", {25'd0, word_cnt}, 32'd0);
        chk("clr_image_zero", {31'd0, os_in_array == 1024'd0}, 32'd1);
        send(16'h0042);
        chk("post_clr_slot0", {16'd0, slot(0)}, 32'h0042);
        chk("post_clr_cnt", {25'd0, word_cnt}, 32'd1);

        // Clear in HOLD together with array_ready
        for (int k = 1; k < N; k++) send(16'h0300 + 16'(k));
        chk("hold2_array_valid", {31'd0, array_valid}, 32'd1);
        clear = 1'b1; array_ready = 1'b1;
        step();
        clear = 1'b0; array_ready = 1'b0;
        chk("clrhold_array_valid", {31'd0, array_valid}, 32'd0);
        chk("clrhold_image_zero", {31'd0, os_in_array == 1024'd0}, 32'd1);

        // Asynchronous reset mid-cycle at word_cnt=10
        for (int k = 0; k < 10; k++) send(16'h0400 + 16'(k));
        chk("pre_rst_cnt", {25'd0, word_cnt}, 32'd10);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_word_cnt", {25'd0, word_cnt}, 32'd0);
        chk("arst_image_zero", {31'd0, os_in_array == 1024'd0}, 32'd1);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_array_valid", {31'd0, array_valid}, 32'd0);
        step();
        reset = 1'b0;
        step();
        send(16'h0077);
        chk("post_rst_slot0", {16'd0, slot(0)}, 32'h0077);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
